// File: rtl/callback_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : callback_rr_arbiter_if
// Brief    : Client-side and resource-side handshake bundle of the shared
//            two-operand Add callback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface callback_rr_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 32
);
    // Client request FIFOs (read side) and result return
    logic [NUM_CLIENTS-1:0]       client_empty_in;
    logic [NUM_CLIENTS*WIDTH-1:0] client_a_in;
    logic [NUM_CLIENTS*WIDTH-1:0] client_b_in;
    logic [NUM_CLIENTS-1:0]       client_rden_out;
    logic [NUM_CLIENTS-1:0]       client_valid_out;
    logic [WIDTH-1:0]             client_result_out;
    logic [NUM_CLIENTS-1:0]       client_rdy_in;

    // Shared callback implementation: ready/valid request, FIFO-read result
    logic                         res_valid_out;
    logic [WIDTH-1:0]             res_a_out;
    logic [WIDTH-1:0]             res_b_out;
    logic                         res_rdy_in;
    logic                         res_empty_in;
    logic [WIDTH-1:0]             res_result_in;
    logic                         res_rden_out;

    // Arbiter side
    modport master (
        input  client_empty_in, client_a_in, client_b_in, client_rdy_in,
               res_rdy_in, res_empty_in, res_result_in,
        output client_rden_out, client_valid_out, client_result_out,
               res_valid_out, res_a_out, res_b_out, res_rden_out
    );

    // Environment side (clients plus shared resource)
    modport slave (
        output client_empty_in, client_a_in, client_b_in, client_rdy_in,
               res_rdy_in, res_empty_in, res_result_in,
        input  client_rden_out, client_valid_out, client_result_out,
               res_valid_out, res_a_out, res_b_out, res_rden_out
    );
endinterface
`default_nettype wire

// File: rtl/callback_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : callback_rr_arbiter
// Brief    : Round-robin sharing of one Add callback datapath between
//            NUM_CLIENTS callers. Requests issue with zero latency; results
//            return in issue order and are steered back by a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module callback_rr_arbiter #(
    parameter int NUM_CLIENTS     = 4,
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    callback_rr_arbiter_if.master              bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_out,
    output logic                               error_out
);

    localparam int c_IDX_W = $clog2(NUM_CLIENTS);
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_CLIENTS - 1);

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_error;
    logic [c_IDX_W-1:0] r_tag_mem [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    logic [WIDTH-1:0]   w_a [NUM_CLIENTS];
    logic [WIDTH-1:0]   w_b [NUM_CLIENTS];
    logic [c_IDX_W-1:0] w_grant;
    logic               w_found;
    logic [c_IDX_W-1:0] w_head;
    logic               w_tags_empty;
    logic               w_issue;
    logic               w_ret;

    // Unpack the flat per-client operand buses
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign w_a[gi] = bus.client_a_in[gi*WIDTH +: WIDTH];
            assign w_b[gi] = bus.client_b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first non-empty client starting at the pointer
    always_comb begin
        logic [c_IDX_W-1:0] w_cand;
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % NUM_CLIENTS);
            if (!w_found && !bus.client_empty_in[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // Full test uses the registered count only: a same-cycle return does
    // not free a slot for an issue in that cycle.
    assign w_head       = r_tag_mem[r_rd_ptr];
    assign w_tags_empty = (r_count == '0);
    assign w_issue      = !rst && bus.res_rdy_in && (r_count < c_MAX) && w_found;
    assign w_ret        = !rst && !bus.res_empty_in && !w_tags_empty
                          && bus.client_rdy_in[w_head];

    // Combinational handshake outputs; everything idles at zero
    always_comb begin
        bus.client_rden_out   = '0;
        bus.client_valid_out  = '0;
        bus.client_result_out = '0;
        bus.res_valid_out     = 1'b0;
        bus.res_a_out         = '0;
        bus.res_b_out         = '0;
        bus.res_rden_out      = 1'b0;
        if (w_issue) begin
            bus.client_rden_out[w_grant] = 1'b1;
            bus.res_valid_out            = 1'b1;
            bus.res_a_out                = w_a[w_grant];
            bus.res_b_out                = w_b[w_grant];
        end
        if (w_ret) begin
            bus.client_valid_out[w_head] = 1'b1;
            bus.client_result_out        = bus.res_result_in;
            bus.res_rden_out             = 1'b1;
        end
    end

    // Pointer, tag FIFO indices, in-flight count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_ptr    <= (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ret) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_issue, w_ret})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A result with no tag to route it is left in the resource FIFO
            if (!bus.res_empty_in && w_tags_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    // Tag storage; validity is tracked by the indices, so no reset needed
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

    assign outstanding_out = r_count;
    assign error_out       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_callback_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_callback_rr_arbiter
// Brief    : Directed self-checking bench for callback_rr_arbiter with a
//            behavioural client-FIFO and fixed-latency adder environment.
// Revision : 1.0 - initial release
// ============================================================================
module tb_callback_rr_arbiter;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int MO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] outstanding_out;
    logic       error_out;

    callback_rr_arbiter_if #(.NUM_CLIENTS(NC), .WIDTH(W)) bus ();

    callback_rr_arbiter #(
        .NUM_CLIENTS     (NC),
        .WIDTH           (W),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .outstanding_out (outstanding_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Client request FIFOs
    logic [W-1:0] req_a [NC][32];
    logic [W-1:0] req_b [NC][32];
    int           req_hd [NC];
    int           req_tl [NC];

    // Environment controls
    logic [NC-1:0] rdy;
    logic          res_rdy;
    int            lat;
    logic          hold;
    logic          spur;

    // Adder model: pipeline and result FIFO
    logic [W-1:0] pipe_val [$];
    int           pipe_due [$];
    logic [W-1:0] outq [$];
    int           cyc;

    // Logs
    int           gnt_cl  [64];
    int           gnt_cyc [64];
    int           gnt_n;
    int           ret_cl  [64];
    logic [W-1:0] ret_val [64];
    int           ret_n;
    int           peak;

    // Outputs sampled at the falling edge of the latest cycle
    logic [NC-1:0] s_rden;
    logic [NC-1:0] s_cvalid;
    logic          s_res_valid;
    logic          s_res_rden;
    logic [W-1:0]  s_res_a;
    logic [W-1:0]  s_res_b;

    task automatic clear_env();
        for (int i = 0; i < NC; i++) begin
            req_hd[i] = 0;
            req_tl[i] = 0;
        end
        rdy     = '1;
        res_rdy = 1'b1;
        lat     = 1;
        hold    = 1'b0;
        spur    = 1'b0;
        pipe_val.delete();
        pipe_due.delete();
        outq.delete();
        gnt_n = 0;
        ret_n = 0;
        peak  = 0;
    endtask

    task automatic push_req(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[c][req_tl[c]] = a;
        req_b[c][req_tl[c]] = b;
        req_tl[c]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NC; i++) begin
            bus.client_empty_in[i] = (req_hd[i] == req_tl[i]);
            if (req_hd[i] != req_tl[i]) begin
                bus.client_a_in[i*W +: W] = req_a[i][req_hd[i]];
                bus.client_b_in[i*W +: W] = req_b[i][req_hd[i]];
            end else begin
                bus.client_a_in[i*W +: W] = '0;
                bus.client_b_in[i*W +: W] = '0;
            end
        end
        bus.client_rdy_in = rdy;
        bus.res_rdy_in    = res_rdy;
        bus.res_empty_in  = hold ? 1'b1 : (spur ? 1'b0 : (outq.size() == 0));
        bus.res_result_in = (outq.size() != 0) ? outq[0] : (spur ? 32'hDEAD_BEEF : '0);
    endtask

    // One clock cycle: drive, sample at negedge, update models, step edge
    task automatic tick();
        apply_inputs();
        @(negedge clk);
        s_rden      = bus.client_rden_out;
        s_cvalid    = bus.client_valid_out;
        s_res_valid = bus.res_valid_out;
        s_res_rden  = bus.res_rden_out;
        s_res_a     = bus.res_a_out;
        s_res_b     = bus.res_b_out;
        if (int'(outstanding_out) > peak) peak = int'(outstanding_out);
        for (int i = 0; i < NC; i++) begin
            if (s_rden[i]) begin
                if (gnt_n < 64) begin
                    gnt_cl[gnt_n]  = i;
                    gnt_cyc[gnt_n] = cyc;
                end
                gnt_n++;
                if (req_hd[i] != req_tl[i]) req_hd[i]++;
            end
        end
        if (s_res_valid && res_rdy) begin
            pipe_val.push_back(s_res_a + s_res_b);
            pipe_due.push_back(cyc + lat);
        end
        if (s_res_rden && outq.size() != 0) void'(outq.pop_front());
        for (int i = 0; i < NC; i++) begin
            if (s_cvalid[i]) begin
                if (ret_n < 64) begin
                    ret_cl[ret_n]  = i;
                    ret_val[ret_n] = bus.client_result_out;
                end
                ret_n++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        while (pipe_due.size() != 0 && pipe_due[0] <= cyc) begin
            outq.push_back(pipe_val.pop_front());
            void'(pipe_due.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_env();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_env();
        push_req(0, 32'd5, 32'd6);
        spur = 1'b1;
        tick();
        checks++; if (s_rden !== '0) begin errors++; $display("FAIL reset_rden got %0h expected 0", s_rden); end
        checks++; if (s_res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b expected 0", s_res_valid); end
        checks++; if (s_res_a !== '0) begin errors++; $display("FAIL reset_res_a got %0h expected 0", s_res_a); end
        checks++; if (s_res_rden !== 1'b0) begin errors++; $display("FAIL reset_res_rden got %0b expected 0", s_res_rden); end
        checks++; if (s_cvalid !== '0) begin errors++; $display("FAIL reset_cvalid got %0h expected 0", s_cvalid); end
        checks++; if (outstanding_out !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d expected 0", outstanding_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error got %0b expected 0", error_out); end
        clear_env();
        rst = 1'b0;
        tick();
        checks++; if (s_res_valid !== 1'b0 || s_res_a !== '0 || s_res_b !== '0) begin
            errors++; $display("FAIL idle_res got valid=%0b a=%0h b=%0h expected all 0", s_res_valid, s_res_a, s_res_b);
        end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL idle_error got %0b expected 0", error_out); end
    endtask

    task automatic test_single_client();
        do_reset();
        lat = 3;
        for (int i = 0; i < 10; i++) push_req(0, W'(i), 32'd100);
        for (int n = 0; n < 100 && ret_n < 10; n++) tick();
        checks++; if (ret_n != 10) begin errors++; $display("FAIL single_count got %0d expected 10", ret_n); end
        for (int k = 0; k < 10 && k < ret_n; k++) begin
            checks++;
            if (ret_cl[k] != 0 || ret_val[k] !== W'(100 + k)) begin
                errors++; $display("FAIL single_result[%0d] got client %0d value %0d expected client 0 value %0d", k, ret_cl[k], ret_val[k], 100 + k);
            end
        end
        checks++; if (peak > 3 || peak < 1) begin errors++; $display("FAIL single_peak got %0d expected 1..3", peak); end
        checks++; if (outstanding_out !== 4'd0) begin errors++; $display("FAIL single_drain got %0d expected 0", outstanding_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL single_error got %0b expected 0", error_out); end
    endtask

    task automatic test_round_robin();
        int kk [NC];
        logic [W-1:0] exp_v;
        do_reset();
        for (int c = 0; c < NC; c++) begin
            kk[c] = 0;
            for (int k = 0; k < 6; k++) push_req(c, W'(1000*c + k), W'(7*k + c + 1));
        end
        for (int n = 0; n < 200 && ret_n < 24; n++) tick();
        checks++; if (gnt_n != 24 || ret_n != 24) begin errors++; $display("FAIL rr_count got grants %0d returns %0d expected 24 24", gnt_n, ret_n); end
        for (int n = 0; n < 24 && n < gnt_n; n++) begin
            checks++;
            if (gnt_cl[n] != n % NC) begin errors++; $display("FAIL rr_grant[%0d] got %0d expected %0d", n, gnt_cl[n], n % NC); end
        end
        if (gnt_n >= 24) begin
            checks++;
            if (gnt_cyc[23] - gnt_cyc[0] != 23) begin errors++; $display("FAIL rr_throughput got span %0d expected 23", gnt_cyc[23] - gnt_cyc[0]); end
        end
        for (int m = 0; m < ret_n && m < 24; m++) begin
            exp_v = W'(1000*ret_cl[m] + kk[ret_cl[m]] + 7*kk[ret_cl[m]] + ret_cl[m] + 1);
            checks++;
            if (ret_val[m] !== exp_v) begin errors++; $display("FAIL rr_result[%0d] client %0d got %0d expected %0d", m, ret_cl[m], ret_val[m], exp_v); end
            kk[ret_cl[m]]++;
        end
    endtask

    task automatic test_tag_full();
        logic [W-1:0] exp_v;
        int           exp_c;
        do_reset();
        hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_req(1, W'(k + 1), W'(10*k));
            push_req(3, W'(50 + k), W'(3*k));
        end
        for (int n = 0; n < 12; n++) tick();
        checks++; if (gnt_n != 8) begin errors++; $display("FAIL full_issues got %0d expected 8", gnt_n); end
        checks++; if (s_res_valid !== 1'b0 || s_res_a !== '0) begin errors++; $display("FAIL full_blocked got valid=%0b a=%0h expected 0 0", s_res_valid, s_res_a); end
        checks++; if (outstanding_out !== 4'd8) begin errors++; $display("FAIL full_outstanding got %0d expected 8", outstanding_out); end
        hold = 1'b0;
        tick();
        checks++; if (s_res_rden !== 1'b1 || s_res_valid !== 1'b0) begin
            errors++; $display("FAIL full_no_bypass got rden=%0b valid=%0b expected 1 0", s_res_rden, s_res_valid);
        end
        for (int n = 0; n < 100 && ret_n < 12; n++) tick();
        checks++; if (ret_n != 12 || gnt_n != 12) begin errors++; $display("FAIL full_resume got returns %0d grants %0d expected 12 12", ret_n, gnt_n); end
        for (int m = 0; m < 12 && m < ret_n; m++) begin
            exp_c = (m % 2 == 0) ? 1 : 3;
            exp_v = (exp_c == 1) ? W'(11*(m/2) + 1) : W'(50 + 4*(m/2));
            checks++;
            if (ret_cl[m] != exp_c || ret_val[m] !== exp_v) begin
                errors++; $display("FAIL full_order[%0d] got client %0d value %0d expected client %0d value %0d", m, ret_cl[m], ret_val[m], exp_c, exp_v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_v;
        do_reset();
        rdy = 4'b1011;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 2; k++) push_req(c, W'(100*c + k), W'(k + 5));
        for (int n = 0; n < 5; n++) tick();
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (s_res_rden !== 1'b0 || s_cvalid !== '0) begin
                errors++; $display("FAIL bp_stall[%0d] got rden=%0b cvalid=%0h expected 0 0", n, s_res_rden, s_cvalid);
            end
        end
        checks++; if (ret_n != 2) begin errors++; $display("FAIL bp_before got %0d returns expected 2", ret_n); end
        rdy = '1;
        tick();
        checks++; if (s_cvalid !== 4'b0100) begin errors++; $display("FAIL bp_release got cvalid=%0h expected 4", s_cvalid); end
        for (int n = 0; n < 50 && ret_n < 8; n++) tick();
        checks++; if (ret_n != 8) begin errors++; $display("FAIL bp_count got %0d expected 8", ret_n); end
        for (int m = 0; m < 8 && m < ret_n; m++) begin
            exp_v = W'(100*(m % NC) + 2*(m / NC) + 5);
            checks++;
            if (ret_cl[m] != m % NC || ret_val[m] !== exp_v) begin
                errors++; $display("FAIL bp_order[%0d] got client %0d value %0d expected client %0d value %0d", m, ret_cl[m], ret_val[m], m % NC, exp_v);
            end
        end
    endtask

    task automatic test_spurious();
        do_reset();
        spur = 1'b1;
        tick();
        checks++; if (s_res_rden !== 1'b0 || s_cvalid !== '0) begin
            errors++; $display("FAIL spur_pop got rden=%0b cvalid=%0h expected 0 0", s_res_rden, s_cvalid);
        end
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL spur_error got %0b expected 1", error_out); end
        spur = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL spur_sticky got %0b expected 1", error_out); end
        do_reset();
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL spur_clear got %0b expected 0", error_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold = 1'b1;
        for (int k = 0; k < 5; k++) push_req(0, W'(k), 32'd1);
        for (int n = 0; n < 5; n++) tick();
        checks++; if (outstanding_out !== 4'd5) begin errors++; $display("FAIL mid_inflight got %0d expected 5", outstanding_out); end
        rst = 1'b1;
        clear_env();
        push_req(0, 32'd21, 32'd2);
        spur = 1'b1;
        tick();
        checks++; if (s_rden !== '0 || s_res_valid !== 1'b0 || s_res_rden !== 1'b0 || s_cvalid !== '0) begin
            errors++; $display("FAIL mid_reset_out got rden=%0h valid=%0b res_rden=%0b cvalid=%0h expected all 0", s_rden, s_res_valid, s_res_rden, s_cvalid);
        end
        checks++; if (outstanding_out !== 4'd0 || error_out !== 1'b0) begin
            errors++; $display("FAIL mid_reset_regs got outstanding=%0d error=%0b expected 0 0", outstanding_out, error_out);
        end
        spur = 1'b0;
        rst  = 1'b0;
        push_req(2, 32'd30, 32'd4);
        for (int n = 0; n < 20 && ret_n < 2; n++) tick();
        checks++; if (gnt_n != 2 || gnt_cl[0] != 0 || gnt_cl[1] != 2) begin
            errors++; $display("FAIL mid_ptr got grants %0d first %0d second %0d expected 2 0 2", gnt_n, gnt_cl[0], gnt_cl[1]);
        end
        checks++; if (ret_n != 2 || ret_cl[0] != 0 || ret_val[0] !== 32'd23 || ret_cl[1] != 2 || ret_val[1] !== 32'd34) begin
            errors++; $display("FAIL mid_results got n=%0d c0=%0d v0=%0d c1=%0d v1=%0d expected 2 0 23 2 34", ret_n, ret_cl[0], ret_val[0], ret_cl[1], ret_val[1]);
        end
        checks++; if (outstanding_out !== 4'd0 || error_out !== 1'b0) begin
            errors++; $display("FAIL mid_final got outstanding=%0d error=%0b expected 0 0", outstanding_out, error_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        clear_env();
        apply_inputs();
        test_reset();
        test_single_client();
        test_round_robin();
        test_tag_full();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/callback_rr_arbiter.md
# callback_rr_arbiter

Shares one FIFO-style callback datapath (the two-operand `Add` callback: arguments `a`, `b`, returning `result`) between `NUM_CLIENTS` independent callers. Requests are granted round-robin and issued to the shared resource with ready/valid. Results come back in issue order through a FIFO-read port and are steered to the originating client through an internal tag FIFO. The block sits between the exported-class callback ports and the single implementation of the callback.

## Interface

Parameters:
- `NUM_CLIENTS`, 4: number of requesters, 2..16.
- `WIDTH`, 32: operand and result width.
- `MAX_OUTSTANDING`, 8: tag FIFO depth, power of two, 2..64; the maximum number of in-flight requests.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `client_empty_in`  in  NUM_CLIENTS  per-client request FIFO empty.
- `client_a_in`  in  NUM_CLIENTS*WIDTH  per-client operand a; client i occupies bits [i*WIDTH +: WIDTH].
- `client_b_in`  in  NUM_CLIENTS*WIDTH  per-client operand b; same packing as `client_a_in`.
- `client_rden_out`  out  NUM_CLIENTS  one-hot pop of the granted client's request FIFO.
- `client_valid_out`  out  NUM_CLIENTS  one-hot result strobe to a client.
- `client_result_out`  out  WIDTH  result, shared by all clients; qualified by `client_valid_out`.
- `client_rdy_in`  in  NUM_CLIENTS  client i can accept a result this cycle.
- `res_valid_out`  out  1  request to the shared resource.
- `res_a_out`  out  WIDTH  operand a to the shared resource.
- `res_b_out`  out  WIDTH  operand b to the shared resource.
- `res_rdy_in`  in  1  resource accepts a request.
- `res_empty_in`  in  1  resource result FIFO empty.
- `res_result_in`  in  WIDTH  resource result FIFO head.
- `res_rden_out`  out  1  pop the resource result FIFO.
- `outstanding_out`  out  clog2(MAX_OUTSTANDING)+1  registered in-flight count.
- `error_out`  out  1  sticky protocol error.

## Operation

- **State:** round-robin pointer `ptr` (0..NUM_CLIENTS-1); tag FIFO of client indices, MAX_OUTSTANDING deep; `count`; `error`.
- **Issue condition:** `issue = !rst && res_rdy_in && count_reg < MAX_OUTSTANDING && any(!client_empty_in)`.
  - The full check uses the registered count only. There is no bypass for a same-cycle return, so a full tag FIFO blocks issue even when a pop happens in the same cycle.
- **Grant:** the first non-empty client searching `ptr, ptr+1, … mod NUM_CLIENTS`.
- **On issue:**
  - `client_rden_out[g]=1`, `res_valid_out=1`, `res_a_out/res_b_out` = client g operands (combinational, same cycle).
  - Push g into the tag FIFO.
  - `ptr <= (g+1) mod NUM_CLIENTS`.
- **No issue:** `ptr` holds. `res_a_out`/`res_b_out` are don't-care, but the bench must drive them to 0 to ease waveform checks.
- **Return condition:** `ret = !rst && !res_empty_in && tag FIFO non-empty && client_rdy_in[head]`.
- **On return:**
  - `res_rden_out=1`, `client_valid_out[head]=1`, `client_result_out=res_result_in`.
  - Pop the tag FIFO.
  - A client that is not ready stalls all returns (head-of-line; results are in order).
- **Count update:** `count <= count + issue - ret`. Issue and return in the same cycle leave it unchanged.
- **Error:** `!res_empty_in` while the tag FIFO is empty sets `error` (sticky until `rst`). The result is not popped.
- **Reset:** while `rst`=1, every combinational output is forced to 0. On the clock edge with `rst`=1: `ptr=0`, `count=0`, tag FIFO emptied, `error=0`.
  - Reset mid-operation discards in-flight tags. The shared resource must be reset in the same cycle.

## Timing

- **Issue latency:** 0 cycles. A client request is popped and presented to the resource in the same cycle; the grant is registered into `ptr` at the next edge.
- **Return latency:** 0 cycles from `res_empty_in` falling (with the client ready) to `client_valid_out`.
- **Throughput:** one issue and one return per cycle sustained.
- **Fairness:** a continuously non-empty client is granted at least once every NUM_CLIENTS issues.
- **Registered outputs:** `outstanding_out` and `error_out`, updated at the clock edge after the event.
- **Reset values:** all outputs are 0 during reset and in the first cycle after it.

## Test plan

1. **Single client:** client 0 holds 10 requests with a=i, b=100, resource is a 3-cycle adder → client 0 receives 100..109 in order; `outstanding_out` peaks at ≤3; `error_out`=0.
2. **All four clients always non-empty, `res_rdy_in`=1** → grants are 0,1,2,3,0,1,… exactly. Each client gets results a+b matched to its own operands. Throughput is 1 per cycle after fill.
3. **Tag full:** resource holds `res_empty_in`=1 with MAX_OUTSTANDING=8 → exactly 8 issues, then `res_valid_out`=0 and `outstanding_out`=8. Release → 8 results arrive in issue order and issue resumes.
4. **Backpressure:** `client_rdy_in[2]`=0 for 20 cycles while its result is at the head → no `res_rden_out` and no other client receives a result. Asserting rdy delivers that result, then the queued ones follow.
5. **Spurious result:** `res_empty_in`=0 with nothing outstanding → `error_out`=1 the next cycle, `res_rden_out`=0. It stays 1 until `rst`.
6. **Reset mid-operation:** assert `rst` with 5 in flight → all outputs 0 during reset. After release, `outstanding_out`=0, `ptr` restarts at client 0, and fresh requests complete correctly.
